// File: rtl/joy_conditioner_pkg.sv
// joy_conditioner_pkg
//   Shared definitions for the joystick conditioner: the bit index of each
//   joystick line on the 5-bit active-low bus, the per-axis SOCD "last
//   pressed" encoding, and the resolver function used on each axis.
package joy_conditioner_pkg;

  localparam int JOY_W     = 5;
  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_FIRE  = 4;

  // Which direction of an axis was pressed most recently.
  // FIRST = up / left, SECOND = down / right.
  typedef enum logic {
    LAST_FIRST  = 1'b0,
    LAST_SECOND = 1'b1
  } socd_last_e;

  // Resolve one axis. st[0] is the first-listed direction, st[1] the second,
  // both active-low. When both are held and resolution is enabled, only the
  // most recently pressed direction stays low.
  function automatic logic [1:0] socd_resolve(
    input logic [1:0] st,
    input socd_last_e last,
    input logic       en
  );
    logic [1:0] res;
    if (en && (st == 2'b00)) begin
      if (last == LAST_FIRST) begin
        res = 2'b10;
      end else begin
        res = 2'b01;
      end
    end else begin
      res = st;
    end
    return res;
  endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// joy_debounce_bit
//   Conditions one active-low joystick pad: two-flop synchroniser followed by
//   a tick-sampled debouncer that only accepts a new level after it has
//   differed from the held state on DB_COUNT consecutive ticks.
// Ports:
//   clk   - pixel clock
//   rst_n - asynchronous active-low reset
//   tick  - one-cycle debounce sample strobe
//   raw   - asynchronous pad input (active-low)
//   state - debounced level (active-low), reset 1
//   press - high in the tick cycle where state is about to go 1 -> 0
module joy_debounce_bit #(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic press
);

  localparam logic [3:0] DB_LIM = 4'(DB_COUNT);

  logic       sync1_r;
  logic       sync2_r;
  logic       state_r;
  logic [3:0] cnt_r;
  logic [3:0] cnt_inc_s;
  logic       flip_s;

  assign cnt_inc_s = cnt_r + 4'd1;
  // A flip happens on a tick where the input still differs and this tick
  // completes the run of DB_COUNT differing samples.
  assign flip_s    = tick && (sync2_r != state_r) && (cnt_inc_s == DB_LIM);
  assign press     = flip_s && state_r;
  assign state     = state_r;

  // Two-stage synchroniser for the asynchronous pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce state and consecutive-difference counter, advanced on ticks only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= 1'b1;
      cnt_r   <= 4'd0;
    end else if (tick) begin
      if (sync2_r == state_r) begin
        cnt_r <= 4'd0;
      end else if (flip_s) begin
        state_r <= ~state_r;
        cnt_r   <= 4'd0;
      end else begin
        cnt_r <= cnt_inc_s;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/joy_conditioner.sv
// joy_conditioner
//   Conditions the five raw active-low joystick pads for the PACMAN core:
//   synchronise + debounce each pad on a slow tick derived from the 6 MHz
//   enable, then resolve opposite-direction conflicts per axis.
// Ports:
//   I_CLK     - pixel clock
//   I_RESET_N - asynchronous active-low reset
//   I_ENA_6   - one-cycle 6 MHz enable
//   I_JOY_RAW - raw pads, active-low (0 up, 1 down, 2 left, 3 right, 4 fire)
//   O_JOY     - conditioned, registered, active-low, same bit order
//   O_CHANGE  - one-cycle pulse in the cycle O_JOY takes a new value
//   O_TICK    - registered copy of the debounce sample tick
module joy_conditioner
  import joy_conditioner_pkg::*;
#(
  parameter int TICK_DIV  = 6000,
  parameter int DB_COUNT  = 4,
  parameter int SOCD_MODE = 1
) (
  input  logic             I_CLK,
  input  logic             I_RESET_N,
  input  logic             I_ENA_6,
  input  logic [JOY_W-1:0] I_JOY_RAW,
  output logic [JOY_W-1:0] O_JOY,
  output logic             O_CHANGE,
  output logic             O_TICK
);

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic            SOCD_EN = (SOCD_MODE != 0);

  logic [PW-1:0]    pre_cnt_r;
  logic             tick_s;
  logic [JOY_W-1:0] state_s;
  logic [JOY_W-1:0] press_s;
  socd_last_e       last_v_r;
  socd_last_e       last_h_r;
  logic [JOY_W-1:0] joy_next_s;
  logic [JOY_W-1:0] joy_r;
  logic             change_r;
  logic             tick_r;

  assign tick_s = I_ENA_6 && (pre_cnt_r == PRE_MAX);

  // Prescaler: counts 6 MHz enables, wraps at TICK_DIV-1.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      pre_cnt_r <= {PW{1'b0}};
    end else if (I_ENA_6) begin
      if (pre_cnt_r == PRE_MAX) begin
        pre_cnt_r <= {PW{1'b0}};
      end else begin
        pre_cnt_r <= pre_cnt_r + PW'(1);
      end
    end else begin
      pre_cnt_r <= pre_cnt_r;
    end
  end

  for (genvar g = 0; g < JOY_W; g++) begin : g_db
    joy_debounce_bit #(
      .DB_COUNT(DB_COUNT)
    ) u_db (
      .clk   (I_CLK),
      .rst_n (I_RESET_N),
      .tick  (tick_s),
      .raw   (I_JOY_RAW[g]),
      .state (state_s[g]),
      .press (press_s[g])
    );
  end

  // Per-axis last-pressed tracking; the first-listed direction wins a tie.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      last_v_r <= LAST_FIRST;
      last_h_r <= LAST_FIRST;
    end else begin
      if (press_s[JOY_UP]) begin
        last_v_r <= LAST_FIRST;
      end else if (press_s[JOY_DOWN]) begin
        last_v_r <= LAST_SECOND;
      end else begin
        last_v_r <= last_v_r;
      end
      if (press_s[JOY_LEFT]) begin
        last_h_r <= LAST_FIRST;
      end else if (press_s[JOY_RIGHT]) begin
        last_h_r <= LAST_SECOND;
      end else begin
        last_h_r <= last_h_r;
      end
    end
  end

  // SOCD resolution from debounced state; fire passes untouched.
  always_comb begin
    joy_next_s = state_s;
    {joy_next_s[JOY_DOWN], joy_next_s[JOY_UP]} =
      socd_resolve({state_s[JOY_DOWN], state_s[JOY_UP]}, last_v_r, SOCD_EN);
    {joy_next_s[JOY_RIGHT], joy_next_s[JOY_LEFT]} =
      socd_resolve({state_s[JOY_RIGHT], state_s[JOY_LEFT]}, last_h_r, SOCD_EN);
  end

  // Output registers: conditioned bus, change strobe and tick strobe.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      joy_r    <= {JOY_W{1'b1}};
      change_r <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      joy_r    <= joy_next_s;
      change_r <= (joy_next_s != joy_r);
      tick_r   <= tick_s;
    end
  end

  assign O_JOY    = joy_r;
  assign O_CHANGE = change_r;
  assign O_TICK   = tick_r;

endmodule

// File: tb/tb_joy_conditioner.sv
// tb_joy_conditioner
//   Scoreboard bench: two conditioners (SOCD on / off) share the same pads.
//   Each stimulus step pushes the hand-computed next O_JOY value of each
//   instance; monitors pop and compare whenever O_CHANGE pulses.
module tb_joy_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [4:0] raw;
  logic [4:0] joy_a, joy_b;
  logic       chg_a, chg_b, tick_a, tick_b;

  int checks = 0;
  int errors = 0;
  int ena_cnt;
  logic [4:0] exp_a[$];
  logic [4:0] exp_b[$];
  logic prev_tick_a = 1'b0;
  logic prev_tick_b = 1'b0;

  joy_conditioner #(.TICK_DIV(4), .DB_COUNT(3), .SOCD_MODE(1)) dut_a (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_ENA_6(ena), .I_JOY_RAW(raw),
    .O_JOY(joy_a), .O_CHANGE(chg_a), .O_TICK(tick_a)
  );

  joy_conditioner #(.TICK_DIV(4), .DB_COUNT(3), .SOCD_MODE(0)) dut_b (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_ENA_6(ena), .I_JOY_RAW(raw),
    .O_JOY(joy_b), .O_CHANGE(chg_b), .O_TICK(tick_b)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  // 6 MHz enable: one cycle in four, driven away from the active edge.
  initial begin
    int phase;
    phase = 0;
    ena = 1'b0;
    forever begin
      @(negedge clk);
      ena = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) ena_cnt <= 0;
    else if (ena) ena_cnt <= ena_cnt + 1;
  end

  // Monitors: pop expected value on every O_CHANGE pulse.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n === 1'b1) begin
      if (chg_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL change_a unexpected: O_JOY=%b required no change", joy_a);
        end else begin
          e = exp_a.pop_front();
          if (joy_a !== e) begin
            errors++;
            $display("FAIL joy_a: got %b required %b", joy_a, e);
          end
        end
        checks++;
        if (!prev_tick_a) begin
          errors++;
          $display("FAIL latency_a: O_TICK in previous cycle %b required 1", prev_tick_a);
        end
      end
      if (chg_b) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL change_b unexpected: O_JOY=%b required no change", joy_b);
        end else begin
          e = exp_b.pop_front();
          if (joy_b !== e) begin
            errors++;
            $display("FAIL joy_b: got %b required %b", joy_b, e);
          end
        end
      end
    end
    prev_tick_a = tick_a;
    prev_tick_b = tick_b;
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Wait for n O_TICK pulses, each bounded.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int lim;
      lim = 0;
      do begin
        @(negedge clk);
        lim++;
      end while (!tick_a && lim < 100);
      if (!tick_a) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout: O_TICK %b required 1 within 100 cycles", tick_a);
      end
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_both(input logic [4:0] a, input logic [4:0] b);
    exp_a.push_back(a);
    exp_b.push_back(b);
  endtask

  initial begin
    raw   = 5'b00000;
    rst_n = 1'b0;
    repeat (6) @(negedge clk);
    check("reset_joy_a", joy_a, 5'b11111);
    check("reset_joy_b", joy_b, 5'b11111);
    check("reset_change", {3'b000, chg_b, chg_a}, 5'b00000);
    check("reset_tick", {3'b000, tick_b, tick_a}, 5'b00000);

    // First tick after release: 4 enables.
    raw = 5'b11111;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(1);
    check("first_tick_enables", 5'(ena_cnt), 5'd4);

    // Clean press / release of fire.
    raw[4] = 1'b0;
    expect_both(5'b01111, 5'b01111);
    wait_ticks(3);
    settle();
    check("fire_pressed", joy_a, 5'b01111);
    raw[4] = 1'b1;
    expect_both(5'b11111, 5'b11111);
    wait_ticks(3);
    settle();

    // Glitch of 2 ticks on up is rejected; a 3-tick press is accepted.
    raw[0] = 1'b0;
    wait_ticks(2);
    raw[0] = 1'b1;
    wait_ticks(4);
    settle();
    check("glitch_rejected", joy_a, 5'b11111);
    raw[0] = 1'b0;
    expect_both(5'b11110, 5'b11110);
    wait_ticks(3);
    settle();

    // Down while up held: last wins in A, both low in B.
    raw[1] = 1'b0;
    expect_both(5'b11101, 5'b11100);
    wait_ticks(3);
    settle();
    check("socd_last_down", {3'b000, joy_a[1:0]}, 5'b00001);
    raw[1] = 1'b1;
    expect_both(5'b11110, 5'b11110);
    wait_ticks(3);
    settle();
    raw[0] = 1'b1;
    expect_both(5'b11111, 5'b11111);
    wait_ticks(3);
    settle();

    // Left and right in the same tick: left wins in A.
    raw[3:2] = 2'b00;
    expect_both(5'b11011, 5'b10011);
    wait_ticks(3);
    settle();
    check("socd_tie", {3'b000, joy_a[3:2]}, 5'b00010);
    raw[3:2] = 2'b11;
    expect_both(5'b11111, 5'b11111);
    wait_ticks(3);
    settle();

    // Reset after 2 of 3 ticks: three fresh ticks needed after release.
    raw[4] = 1'b0;
    wait_ticks(2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_joy", joy_a, 5'b11111);
    rst_n = 1'b1;
    wait_ticks(2);
    settle();
    check("midreset_two_ticks", joy_a, 5'b11111);
    expect_both(5'b01111, 5'b01111);
    wait_ticks(1);
    settle();
    check("midreset_third_tick", joy_a, 5'b01111);
    raw[4] = 1'b1;
    expect_both(5'b11111, 5'b11111);
    wait_ticks(3);
    settle();

    check("queue_a_drained", 5'(exp_a.size()), 5'd0);
    check("queue_b_drained", 5'(exp_b.size()), 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
